// File: rtl/mem_port_sched_if.sv
// Memory-port scheduler bus.
// Carries the two requester handshakes (fetch f_*, data d_*) and the memory-side
// controls (MAR load and address, MBR control bits, memory strobes, busy).
//   slave  : the scheduler (takes requests, drives acks and memory controls)
//   master : the requesters / control unit side
interface mem_port_sched_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic              d_ack;
  logic              mar_ld;
  logic [ADDR_W-1:0] mar_addr;
  logic [31:0]       mbr_ctrl;
  logic              mem_rd;
  logic              mem_wr;
  logic              busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr,
    output f_ack, d_ack, mar_ld, mar_addr, mbr_ctrl, mem_rd, mem_wr, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr,
    input  f_ack, d_ack, mar_ld, mar_addr, mbr_ctrl, mem_rd, mem_wr, busy
  );
endinterface

// File: rtl/mem_port_sched.sv
// mem_port_sched: shares the single MAR/MBR/memory path between instruction fetch
// and execute-stage load/store. Round-robin arbitration in IDLE, then a fixed
// cycle-by-cycle sequence per access; every output is a flop.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   io_bus  mem_port_sched_if.slave: f_req/f_addr/f_ack, d_req/d_we/d_addr/d_ack,
//           mar_ld/mar_addr, mbr_ctrl (bit3 MBR<-mem, bit19 MBR->mem,
//           bit20 MBR<-ACC), mem_rd, mem_wr, busy
module mem_port_sched #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_port_sched_if.slave        io_bus
);

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned CTRL_W      = 32;
  localparam int unsigned BIT_MBR_LD  = 3;   // MBR <- memory
  localparam int unsigned BIT_MBR_OUT = 19;  // MBR -> memory
  localparam int unsigned BIT_MBR_ACC = 20;  // MBR <- ACC

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RD_WAIT,
    S_RD_LATCH,
    S_WR_STAGE,
    S_WR_DRIVE,
    S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_last_data, w_last_data_nxt;
  logic                r_sel_data, w_sel_data_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic                w_grant_data;

  logic                r_mar_ld, w_mar_ld_nxt;
  logic                r_mem_rd, w_mem_rd_nxt;
  logic                r_mem_wr, w_mem_wr_nxt;
  logic                r_f_ack, w_f_ack_nxt;
  logic                r_d_ack, w_d_ack_nxt;
  logic                r_busy, w_busy_nxt;
  logic [CTRL_W-1:0]   r_mbr_ctrl, w_mbr_ctrl_nxt;

  logic [CNT_W-1:0]    w_cnt_last;
  assign w_cnt_last = CNT_W'(MEM_LAT - 1);

  // State, access latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_last_data <= 1'b1;  // fetch wins the first tie
      r_sel_data  <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_mar_ld    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_f_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_busy      <= 1'b0;
      r_mbr_ctrl  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_data <= w_last_data_nxt;
      r_sel_data  <= w_sel_data_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_mar_ld    <= w_mar_ld_nxt;
      r_mem_rd    <= w_mem_rd_nxt;
      r_mem_wr    <= w_mem_wr_nxt;
      r_f_ack     <= w_f_ack_nxt;
      r_d_ack     <= w_d_ack_nxt;
      r_busy      <= w_busy_nxt;
      r_mbr_ctrl  <= w_mbr_ctrl_nxt;
    end
  end

  // Next state, grant/latch and output decode of the next state.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_last_data_nxt = r_last_data;
    w_sel_data_nxt  = r_sel_data;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_grant_data    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (io_bus.f_req || io_bus.d_req) begin
          // On a tie the requester that did not win last time gets the port.
          w_grant_data    = io_bus.d_req && (!io_bus.f_req || !r_last_data);
          w_sel_data_nxt  = w_grant_data;
          w_last_data_nxt = w_grant_data;
          w_addr_nxt      = w_grant_data ? io_bus.d_addr : io_bus.f_addr;
          w_we_nxt        = w_grant_data && io_bus.d_we;
          w_state_nxt     = S_ADDR;
        end
      end
      S_ADDR: begin
        w_cnt_nxt   = '0;
        w_state_nxt = r_we ? S_WR_STAGE : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (r_cnt == w_cnt_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RD_LATCH;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RD_LATCH: w_state_nxt = S_DONE;
      S_WR_STAGE: w_state_nxt = S_WR_DRIVE;
      S_WR_DRIVE: begin
        if (r_cnt == w_cnt_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are flopped copies of the decode of the state being entered.
    w_mar_ld_nxt   = (w_state_nxt == S_ADDR);
    w_mem_rd_nxt   = (w_state_nxt == S_RD_WAIT) || (w_state_nxt == S_RD_LATCH);
    w_mem_wr_nxt   = (w_state_nxt == S_WR_DRIVE);
    w_f_ack_nxt    = (w_state_nxt == S_DONE) && !w_sel_data_nxt;
    w_d_ack_nxt    = (w_state_nxt == S_DONE) && w_sel_data_nxt;
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_mbr_ctrl_nxt = '0;
    w_mbr_ctrl_nxt[BIT_MBR_LD]  = (w_state_nxt == S_RD_LATCH);
    w_mbr_ctrl_nxt[BIT_MBR_OUT] = (w_state_nxt == S_WR_DRIVE);
    w_mbr_ctrl_nxt[BIT_MBR_ACC] = (w_state_nxt == S_WR_STAGE);
  end

  assign io_bus.f_ack    = r_f_ack;
  assign io_bus.d_ack    = r_d_ack;
  assign io_bus.mar_ld   = r_mar_ld;
  assign io_bus.mar_addr = r_addr;
  assign io_bus.mbr_ctrl = r_mbr_ctrl;
  assign io_bus.mem_rd   = r_mem_rd;
  assign io_bus.mem_wr   = r_mem_wr;
  assign io_bus.busy     = r_busy;

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: two instances (MEM_LAT=2 and MEM_LAT=1) checked every
// cycle against a transaction-timeline model, plus literal per-cycle expectations
// for the directed scenarios.
module tb_mem_port_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_sched_if #(.ADDR_W(8)) b2 ();
  mem_port_sched_if #(.ADDR_W(8)) b1 ();

  mem_port_sched #(.MEM_LAT(2), .ADDR_W(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .io_bus(b2.slave));
  mem_port_sched #(.MEM_LAT(1), .ADDR_W(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_bus(b1.slave));

  // Output vector layout: {mar_ld, mem_rd, mem_wr, f_ack, d_ack, busy, mbr_ctrl[31:0], mar_addr[7:0]}
  logic [45:0] dv0, dv1;
  assign dv0 = {b2.mar_ld, b2.mem_rd, b2.mem_wr, b2.f_ack, b2.d_ack, b2.busy, b2.mbr_ctrl, b2.mar_addr};
  assign dv1 = {b1.mar_ld, b1.mem_rd, b1.mem_wr, b1.f_ack, b1.d_ack, b1.busy, b1.mbr_ctrl, b1.mar_addr};

  logic       in_freq [2];
  logic       in_dreq [2];
  logic       in_dwe  [2];
  logic [7:0] in_faddr[2];
  logic [7:0] in_daddr[2];
  assign in_freq[0] = b2.f_req;  assign in_freq[1] = b1.f_req;
  assign in_dreq[0] = b2.d_req;  assign in_dreq[1] = b1.d_req;
  assign in_dwe[0]  = b2.d_we;   assign in_dwe[1]  = b1.d_we;
  assign in_faddr[0] = b2.f_addr; assign in_faddr[1] = b1.f_addr;
  assign in_daddr[0] = b2.d_addr; assign in_daddr[1] = b1.d_addr;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic logic [45:0] v(input bit ml, input bit rd, input bit wr, input bit fa,
                                    input bit da, input bit bz, input logic [31:0] mbr,
                                    input logic [7:0] a);
    return {ml, rd, wr, fa, da, bz, mbr, a};
  endfunction

  // Expected outputs t cycles after the grant-sampling cycle of an access.
  function automatic logic [45:0] exp_vec(input int lat, input bit act, input int t, input bit we,
                                          input bit sd, input logic [7:0] addr);
    logic ml, rd, wr, fa, da, bz;
    logic [31:0] mbr;
    ml = 0; rd = 0; wr = 0; fa = 0; da = 0; bz = 0; mbr = '0;
    if (act) begin
      bz = 1;
      ml = (t == 1);
      if (!we) begin
        rd = (t >= 2) && (t <= 2 + lat);
        mbr[3] = (t == 2 + lat);
      end else begin
        mbr[20] = (t == 2);
        wr = (t >= 3) && (t <= 2 + lat);
        mbr[19] = wr;
      end
      if (t == 3 + lat) begin
        fa = !sd;
        da = sd;
      end
    end
    return {ml, rd, wr, fa, da, bz, mbr, addr};
  endfunction

  // Model state per instance: access in flight, cycle offset, latched request.
  bit         m_act [2];
  int         m_t   [2];
  bit         m_we  [2];
  bit         m_sd  [2];
  bit         m_lastd[2];
  logic [7:0] m_addr[2];

  initial begin
    bit pd;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          m_act[k] = 0; m_t[k] = 0; m_we[k] = 0; m_sd[k] = 0; m_lastd[k] = 1; m_addr[k] = '0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (!m_act[k]) begin
            if (in_freq[k] || in_dreq[k]) begin
              pd = in_dreq[k] && (!in_freq[k] || !m_lastd[k]);
              m_act[k] = 1; m_t[k] = 1; m_sd[k] = pd; m_lastd[k] = pd;
              m_addr[k] = pd ? in_daddr[k] : in_faddr[k];
              m_we[k] = pd && in_dwe[k];
            end
          end else if (m_t[k] == 3 + lat_of(k)) begin
            m_act[k] = 0;
          end else begin
            m_t[k] = m_t[k] + 1;
          end
        end
      end
    end
  end

  // Literal expectation for the current cycle, set by the stimulus process.
  bit          lit_en = 0;
  int          lit_sel = 0;
  logic [45:0] lit_mask = '1;
  logic [45:0] lit_exp = '0;
  string       lit_nm = "";

  int n_total = 0;
  int n_bad   = 0;

  // Single compare process, mid-cycle.
  initial begin
    logic [45:0] ev, dv;
    logic [31:0] mbr;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        dv = (k == 0) ? dv0 : dv1;
        ev = exp_vec(lat_of(k), m_act[k], m_t[k], m_we[k], m_sd[k], m_addr[k]);
        n_total++;
        if (dv !== ev) begin
          n_bad++;
          $display("FAIL model_lat%0d @%0t got=%h want=%h", lat_of(k), $time, dv, ev);
        end
        mbr = dv[39:8];
        n_total++;
        if (!(($countones(mbr) <= 1) && ((mbr & ~32'h0018_0008) == 0) && !(dv[44] && dv[43]))) begin
          n_bad++;
          $display("FAIL excl_lat%0d @%0t got mbr=%h rd=%b wr=%b want onehot0 and not rd&wr",
                   lat_of(k), $time, mbr, dv[44], dv[43]);
        end
      end
      if (lit_en) begin
        dv = (lit_sel == 0) ? dv0 : dv1;
        n_total++;
        if ((dv & lit_mask) !== (lit_exp & lit_mask)) begin
          n_bad++;
          $display("FAIL %s @%0t got=%h want=%h", lit_nm, $time, dv & lit_mask, lit_exp & lit_mask);
        end
      end
    end
  end

  task automatic step(input int d, input logic [45:0] m, input logic [45:0] e, input string nm);
    @(posedge clk);
    #2;
    lit_sel = d; lit_mask = m; lit_exp = e; lit_nm = nm; lit_en = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      lit_en = 0;
    end
  endtask

  localparam logic [45:0] M_ALL = '1;
  localparam logic [45:0] M_KEY = {1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 8'hFF};

  initial begin
    logic [45:0] e;
    rst_n = 1;
    b2.f_req = 0; b2.f_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0;
    b1.f_req = 0; b1.f_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0;
    #1 rst_n = 0;
    step(0, M_ALL, '0, "rst_lat2");
    step(1, M_ALL, '0, "rst_lat1");
    rst_n = 1;
    idle(2);

    // T1: fetch read
    b2.f_req = 1; b2.f_addr = 8'h10;
    step(0, M_ALL, v(1,0,0,0,0,1,32'h0,8'h10), "t1_c1");
    step(0, M_ALL, v(0,1,0,0,0,1,32'h0,8'h10), "t1_c2");
    step(0, M_ALL, v(0,1,0,0,0,1,32'h0,8'h10), "t1_c3");
    step(0, M_ALL, v(0,1,0,0,0,1,32'h8,8'h10), "t1_c4");
    step(0, M_ALL, v(0,0,0,1,0,1,32'h0,8'h10), "t1_c5");
    b2.f_req = 0;
    step(0, M_ALL, v(0,0,0,0,0,0,32'h0,8'h10), "t1_c6");

    // T2: data store
    b2.d_req = 1; b2.d_we = 1; b2.d_addr = 8'h3C;
    step(0, M_ALL, v(1,0,0,0,0,1,32'h0,8'h3C), "t2_c1");
    step(0, M_ALL, v(0,0,0,0,0,1,32'h0010_0000,8'h3C), "t2_c2");
    step(0, M_ALL, v(0,0,1,0,0,1,32'h0008_0000,8'h3C), "t2_c3");
    step(0, M_ALL, v(0,0,1,0,0,1,32'h0008_0000,8'h3C), "t2_c4");
    step(0, M_ALL, v(0,0,0,0,1,1,32'h0,8'h3C), "t2_c5");
    b2.d_req = 0; b2.d_we = 0;
    step(0, M_ALL, v(0,0,0,0,0,0,32'h0,8'h3C), "t2_c6");

    // T5: inputs changed and req dropped mid-store
    b2.d_req = 1; b2.d_we = 1; b2.d_addr = 8'h55;
    step(0, M_ALL, v(1,0,0,0,0,1,32'h0,8'h55), "t5_c1");
    step(0, M_ALL, v(0,0,0,0,0,1,32'h0010_0000,8'h55), "t5_c2");
    step(0, M_ALL, v(0,0,1,0,0,1,32'h0008_0000,8'h55), "t5_c3");
    b2.d_addr = 8'hFF; b2.d_we = 0; b2.d_req = 0;
    step(0, M_ALL, v(0,0,1,0,0,1,32'h0008_0000,8'h55), "t5_c4");
    step(0, M_ALL, v(0,0,0,0,1,1,32'h0,8'h55), "t5_c5");
    step(0, M_ALL, v(0,0,0,0,0,0,32'h0,8'h55), "t5_c6");

    // T3: contention from reset, grants fetch, data, fetch
    idle(1);
    rst_n = 0;
    step(0, M_ALL, '0, "t3_rst");
    rst_n = 1;
    b2.f_req = 1; b2.f_addr = 8'h20; b2.d_req = 1; b2.d_we = 0; b2.d_addr = 8'h40;
    for (int c = 1; c <= 17; c++) begin
      e = v((c == 1) || (c == 7) || (c == 13), 0, 0, (c == 5) || (c == 17), (c == 11), 0, 32'h0,
            ((c >= 7) && (c < 13)) ? 8'h40 : 8'h20);
      step(0, M_KEY, e, $sformatf("t3_c%0d", c));
    end
    b2.f_req = 0; b2.d_req = 0;
    step(0, M_ALL, v(0,0,0,0,0,0,32'h0,8'h20), "t3_c18");

    // T4: reset during RD_WAIT, then pending data request
    idle(1);
    b2.f_req = 1; b2.f_addr = 8'h66;
    step(0, M_ALL, v(1,0,0,0,0,1,32'h0,8'h66), "t4_c1");
    step(0, M_ALL, '0, "t4_rst");
    rst_n = 0;
    b2.f_req = 0; b2.d_req = 1; b2.d_we = 0; b2.d_addr = 8'h77;
    step(0, M_ALL, '0, "t4_hold");
    rst_n = 1;
    step(0, M_ALL, v(1,0,0,0,0,1,32'h0,8'h77), "t4_g1");
    step(0, M_ALL, v(0,1,0,0,0,1,32'h0,8'h77), "t4_g2");
    step(0, M_ALL, v(0,1,0,0,0,1,32'h0,8'h77), "t4_g3");
    step(0, M_ALL, v(0,1,0,0,0,1,32'h8,8'h77), "t4_g4");
    step(0, M_ALL, v(0,0,0,0,1,1,32'h0,8'h77), "t4_g5");
    b2.d_req = 0;
    step(0, M_ALL, v(0,0,0,0,0,0,32'h0,8'h77), "t4_g6");

    // T6: MEM_LAT=1 read
    b1.f_req = 1; b1.f_addr = 8'h99;
    step(1, M_ALL, v(1,0,0,0,0,1,32'h0,8'h99), "t6_c1");
    step(1, M_ALL, v(0,1,0,0,0,1,32'h0,8'h99), "t6_c2");
    step(1, M_ALL, v(0,1,0,0,0,1,32'h8,8'h99), "t6_c3");
    step(1, M_ALL, v(0,0,0,1,0,1,32'h0,8'h99), "t6_c4");
    b1.f_req = 0;
    step(1, M_ALL, v(0,0,0,0,0,0,32'h0,8'h99), "t6_c5");

    // Random traffic on both instances; requesters hold req until their ack.
    for (int n = 0; n < 400; n++) begin
      idle(1);
      if (b2.f_req && b2.f_ack) b2.f_req = 0;
      else if (!b2.f_req && $urandom_range(3) == 0) begin b2.f_req = 1; b2.f_addr = 8'($urandom); end
      if (b2.d_req && b2.d_ack) b2.d_req = 0;
      else if (!b2.d_req && $urandom_range(3) == 0) begin
        b2.d_req = 1; b2.d_addr = 8'($urandom); b2.d_we = 1'($urandom);
      end
      if (b1.f_req && b1.f_ack) b1.f_req = 0;
      else if (!b1.f_req && $urandom_range(3) == 0) begin b1.f_req = 1; b1.f_addr = 8'($urandom); end
      if (b1.d_req && b1.d_ack) b1.d_req = 0;
      else if (!b1.d_req && $urandom_range(3) == 0) begin
        b1.d_req = 1; b1.d_addr = 8'($urandom); b1.d_we = 1'($urandom);
      end
    end
    b2.f_req = 0; b2.d_req = 0; b1.f_req = 0; b1.d_req = 0;
    idle(12);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
